// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl_pkg
// Description : Shared definitions for the data-memory access controller.
//               Holds the dump FSM state encoding, the word size, and the
//               debug-command field widths. Keeping the widths here lets the
//               UART debug unit and the controller agree on them.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_ctrl_pkg;

  // Dump sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bytes per dumped word
  localparam int WORD_BYTES = 4;

  // Debug-unit command field widths (byte address and word count)
  localparam int DBG_ADDR_WIDTH = 12;
  localparam int DBG_CNT_WIDTH  = 11;

endpackage : dmem_access_ctrl_pkg
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Owner of the data-RAM port. In IDLE the MEM stage drives the
//               RAM combinationally (stores blocked while halted). While the
//               pipeline is halted, a debug dump request is sequenced as a
//               stream of aligned 32-bit word reads handed out over a
//               valid/ready handshake.
// Ports       : i_clk, i_reset_n    - clock, async active-low reset
//               i_halt              - pipeline halted
//               i_pipe_*            - MEM-stage address / store data / strobe
//               i_dbg_start/base/count - dump request
//               i_dbg_ready, o_dbg_data, o_dbg_valid - word stream
//               o_dbg_busy/done/abort  - dump status
//               o_mem_addr/wdata/we, i_mem_rdata - RAM port (async read)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_halt,
  input  logic [ADDR_WIDTH-1:0] i_pipe_addr,
  input  logic [31:0]           i_pipe_wdata,
  input  logic                  i_pipe_write,
  input  logic                  i_dbg_start,
  input  logic [ADDR_WIDTH-1:0] i_dbg_base,
  input  logic [CNT_WIDTH-1:0]  i_dbg_count,
  input  logic                  i_dbg_ready,
  output logic [31:0]           o_dbg_data,
  output logic                  o_dbg_valid,
  output logic                  o_dbg_busy,
  output logic                  o_dbg_done,
  output logic                  o_dbg_abort,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_mem_we,
  input  logic [31:0]           i_mem_rdata
);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [CNT_WIDTH-1:0]  r_rem, w_rem_nxt;
  logic [31:0]           r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_abort, w_abort_nxt;

  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_mem_we;
  logic                  w_done;

  // Dump base is forced word-aligned, so the low two bits are never used.
  logic w_unused;
  assign w_unused = ^i_dbg_base[1:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_abort_nxt = 1'b0;
    w_mem_addr  = r_addr;
    w_mem_we    = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      IDLE: begin
        w_mem_addr = i_pipe_addr;
        w_mem_we   = i_pipe_write & ~i_halt;
        if (i_dbg_start && i_halt) begin
          if (i_dbg_count == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_addr_nxt  = {i_dbg_base[ADDR_WIDTH-1:2], 2'b00};
            w_rem_nxt   = i_dbg_count;
            w_state_nxt = READ;
          end
        end
      end

      READ: begin
        if (!i_halt) begin
          w_valid_nxt = 1'b0;
          w_abort_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_data_nxt  = i_mem_rdata;
          w_valid_nxt = 1'b1;
          w_state_nxt = SEND;
        end
      end

      SEND: begin
        // Abort wins over a same-cycle handshake: that word is not delivered.
        if (!i_halt) begin
          w_valid_nxt = 1'b0;
          w_abort_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_valid && i_dbg_ready) begin
          w_valid_nxt = 1'b0;
          w_rem_nxt   = r_rem - CNT_WIDTH'(1);
          if (r_rem == CNT_WIDTH'(1)) begin
            w_state_nxt = DONE;
          end else begin
            // Natural overflow wraps the address to 0 at the top of RAM.
            w_addr_nxt  = r_addr + ADDR_WIDTH'(WORD_BYTES);
            w_state_nxt = READ;
          end
        end
      end

      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_dbg_data  = r_data;
  assign o_dbg_valid = r_valid;
  assign o_dbg_busy  = (r_state != IDLE);
  assign o_dbg_done  = w_done;
  assign o_dbg_abort = r_abort;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_wdata = i_pipe_wdata;
  // No RAM write may slip through while reset is held.
  assign o_mem_we    = w_mem_we & i_reset_n;

endmodule : dmem_access_ctrl
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Self-checking bench for dmem_access_ctrl. A RAM model sits on
//               the memory port; expected dump words are queued by the
//               stimulus and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

  localparam int AW = 12;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt = 1'b0;
  logic [AW-1:0] pipe_addr = '0;
  logic [31:0]   pipe_wdata = '0;
  logic          pipe_write = 1'b0;
  logic          dbg_start = 1'b0;
  logic [AW-1:0] dbg_base = '0;
  logic [CW-1:0] dbg_count = '0;
  logic          dbg_ready = 1'b0;
  logic [31:0]   dbg_data;
  logic          dbg_valid, dbg_busy, dbg_done, dbg_abort;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_we;

  logic [31:0]   mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_abort  = 0;
  int done_cyc = 0;
  logic [31:0] exp_q [$];

  dmem_access_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_halt(halt),
    .i_pipe_addr(pipe_addr), .i_pipe_wdata(pipe_wdata), .i_pipe_write(pipe_write),
    .i_dbg_start(dbg_start), .i_dbg_base(dbg_base), .i_dbg_count(dbg_count),
    .i_dbg_ready(dbg_ready), .o_dbg_data(dbg_data), .o_dbg_valid(dbg_valid),
    .o_dbg_busy(dbg_busy), .o_dbg_done(dbg_done), .o_dbg_abort(dbg_abort),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: async read, synchronous write
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard on handshakes, plus done/abort pulse accounting
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg_valid && dbg_ready && halt) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", dbg_data, 32'hFFFF_FFFF);
        end else begin
          check("dump_word", dbg_data, exp_q.pop_front());
        end
      end
      if (dbg_done) begin
        n_done++;
        done_cyc = cyc;
        check("busy_in_done", {31'd0, dbg_busy}, 32'd1);
      end
      if (dbg_abort) n_abort++;
    end
  end

  task automatic pipe_store(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pipe_addr = a; pipe_wdata = d; pipe_write = 1'b1;
    @(posedge clk); #1;
    pipe_write = 1'b0;
  endtask

  // Start is sampled at edge k (returned); returns 1 ns after edge k.
  task automatic start_dump(input logic [AW-1:0] b, input logic [CW-1:0] c, output int k);
    @(posedge clk); #1;
    dbg_base = b; dbg_count = c; dbg_start = 1'b1;
    k = cyc + 1;
    @(posedge clk); #1;
    dbg_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_done != d0) break;
    end
    if (i == 200) check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (dbg_valid) break;
    end
    if (i == 100) check({name, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    int d0;
    int a0;

    // Reset state
    #12;
    check("rst_valid", {31'd0, dbg_valid}, 32'd0);
    check("rst_busy",  {31'd0, dbg_busy},  32'd0);
    check("rst_data",  dbg_data, 32'd0);
    check("rst_done_abort", {30'd0, dbg_done, dbg_abort}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle pass-through, then store blocked when halted
    @(posedge clk); #1;
    pipe_addr = 12'h010; pipe_wdata = 32'hDEADBEEF; pipe_write = 1'b1; halt = 1'b0;
    #2;
    check("pass_we",    {31'd0, mem_we}, 32'd1);
    check("pass_addr",  {20'd0, mem_addr}, 32'h010);
    check("pass_wdata", mem_wdata, 32'hDEADBEEF);
    halt = 1'b1;
    #1;
    check("halt_blocks_we", {31'd0, mem_we}, 32'd0);
    pipe_write = 1'b0;
    halt = 1'b0;

    // Preload RAM through the pipeline port
    pipe_store(12'h100, 32'h11111111);
    pipe_store(12'h104, 32'h22222222);
    pipe_store(12'h108, 32'h33333333);
    pipe_store(12'h200, 32'hAAAA0001);
    pipe_store(12'h204, 32'hAAAA0002);
    pipe_store(12'h300, 32'h30300000);
    pipe_store(12'h304, 32'h30300004);
    pipe_store(12'hFFC, 32'hC0C0C0C0);
    pipe_store(12'h000, 32'h0BADF00D);
    @(posedge clk); #1;
    halt = 1'b1;

    // Dump 3 words from unaligned base 0x102, ready held high
    dbg_ready = 1'b1;
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333);
    d0 = n_done;
    start_dump(12'h102, 11'd3, k);
    wait_done(d0, "dump3");
    check("dump3_done_time", done_cyc - k, 32'd6);
    check("dump3_q_empty", exp_q.size(), 32'd0);

    // Backpressure: ready low for 5 cycles while word is presented
    dbg_ready = 1'b0;
    d0 = n_done;
    start_dump(12'h200, 11'd2, k);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_data",  dbg_data, 32'hAAAA0001);
      check("bp_valid", {31'd0, dbg_valid}, 32'd1);
      check("bp_addr",  {20'd0, mem_addr}, 32'h200);
      @(negedge clk); #1;
    end
    exp_q.push_back(32'hAAAA0001);
    exp_q.push_back(32'hAAAA0002);
    @(posedge clk); #1;
    dbg_ready = 1'b1;
    wait_done(d0, "bp");
    check("bp_q_empty", exp_q.size(), 32'd0);

    // Address wrap: 0xFFC then 0x000
    exp_q.push_back(32'hC0C0C0C0);
    exp_q.push_back(32'h0BADF00D);
    d0 = n_done;
    start_dump(12'hFFC, 11'd2, k);
    wait_done(d0, "wrap");
    check("wrap_q_empty", exp_q.size(), 32'd0);

    // Abort while word 2 of 4 is presented
    dbg_ready = 1'b0;
    d0 = n_done;
    a0 = n_abort;
    start_dump(12'h300, 11'd4, k);
    wait_valid("ab1");
    exp_q.push_back(32'h30300000);
    @(posedge clk); #1;
    dbg_ready = 1'b1;
    @(posedge clk); #1;
    dbg_ready = 1'b0;
    wait_valid("ab2");
    check("ab_word2", dbg_data, 32'h30300004);
    halt = 1'b0;
    @(negedge clk); #1;
    check("ab_pulse", {31'd0, dbg_abort}, 32'd1);
    check("ab_valid_low", {31'd0, dbg_valid}, 32'd0);
    check("ab_idle", {31'd0, dbg_busy}, 32'd0);
    @(negedge clk); #1;
    check("ab_pulse_1cyc", {31'd0, dbg_abort}, 32'd0);
    check("ab_count", n_abort - a0, 32'd1);
    check("ab_no_done", n_done - d0, 32'd0);
    check("ab_q_empty", exp_q.size(), 32'd0);
    halt = 1'b1;

    // Count 0: done pulse only
    d0 = n_done;
    start_dump(12'h100, 11'd0, k);
    wait_done(d0, "cnt0");
    check("cnt0_done_time", done_cyc - k, 32'd0);
    check("cnt0_no_valid", {31'd0, dbg_valid}, 32'd0);

    // Start while not halted: ignored
    halt = 1'b0;
    d0 = n_done;
    start_dump(12'h100, 11'd2, k);
    for (int i = 0; i < 4; i++) begin
      check("nohalt_busy", {31'd0, dbg_busy}, 32'd0);
      @(negedge clk); #1;
    end
    check("nohalt_no_done", n_done - d0, 32'd0);
    halt = 1'b1;

    // Async reset mid-READ
    start_dump(12'h100, 11'd2, k);
    check("pre_rst_busy", {31'd0, dbg_busy}, 32'd1);
    #1;
    halt = 1'b0;
    pipe_write = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'd0, dbg_busy},  32'd0);
    check("arst_valid", {31'd0, dbg_valid}, 32'd0);
    check("arst_data",  dbg_data, 32'd0);
    check("arst_pulses", {30'd0, dbg_done, dbg_abort}, 32'd0);
    check("arst_we_forced", {31'd0, mem_we}, 32'd0);
    pipe_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_pulses", {30'd0, dbg_done, dbg_abort}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_access_ctrl
`default_nettype wire
